// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared constants and scan state type for the LED matrix row scanner
package matrix_pkg;

    localparam int ROWS = 7;

    localparam logic [2:0] ROW_FIRST = 3'b001;
    localparam logic [2:0] ROW_LAST  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BLANK,
        ST_SHOW
    } scan_state_t;

endpackage

// File: rtl/frame_buffer.sv
// rtl/frame_buffer.sv - double-buffered ROWS x COLS frame store with shadow write and select toggle
module frame_buffer
    import matrix_pkg::*;
#(
    parameter int COLS = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr,
    input  logic [2:0]      wr_row,
    input  logic [COLS-1:0] wr_data,
    input  logic            toggle,
    input  logic [2:0]      rd_row,
    output logic [COLS-1:0] rd_data
);

    logic            sel;
    logic [COLS-1:0] bank0 [ROWS];
    logic [COLS-1:0] bank1 [ROWS];
    logic [2:0]      wr_idx;
    logic [2:0]      rd_idx;

    assign wr_idx = wr_row - 3'd1;
    assign rd_idx = rd_row - 3'd1;

    // Writes always target the current shadow; during a toggle that is the bank becoming active.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel <= 1'b0;
            for (int i = 0; i < ROWS; i++) begin
                bank0[i] <= '0;
                bank1[i] <= '0;
            end
        end else begin
            if (wr && wr_row != 3'd0) begin
                if (sel) bank0[wr_idx] <= wr_data;
                else     bank1[wr_idx] <= wr_data;
            end
            if (toggle) sel <= ~sel;
        end
    end

    // Read looks through a toggle in progress so a row loaded at the swap edge sees the new frame.
    always_comb begin
        rd_data = '0;
        if (rd_row != 3'd0) begin
            rd_data = (sel ^ toggle) ? bank1[rd_idx] : bank0[rd_idx];
        end
    end

endmodule

// File: rtl/matrix_scan.sv
// rtl/matrix_scan.sv - cyclic 7-row scanner driving the line decoder from a tear-free frame store
module matrix_scan
    import matrix_pkg::*;
#(
    parameter int DWELL = 50000,
    parameter int BLANK = 8,
    parameter int COLS  = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            En,
    input  logic            Wr,
    input  logic [2:0]      Wr_row,
    input  logic [COLS-1:0] Wr_data,
    input  logic            Swap,
    output logic            Swap_ack,
    output logic            V,
    output logic            Ch2,
    output logic            Ch1,
    output logic            Ch0,
    output logic [COLS-1:0] Col,
    output logic            Frame_tick
);

    localparam int CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] DWELL_LD = CW'(DWELL - 1);
    localparam logic [CW-1:0] BLANK_LD = CW'((BLANK > 0) ? BLANK - 1 : 0);

    scan_state_t     state, state_n;
    logic [2:0]      row, row_n, row_adv;
    logic [CW-1:0]   cnt, cnt_n;
    logic            pending;
    logic            last_show_n;
    logic            swap_go;
    logic            row_load;
    logic [COLS-1:0] rd_data;

    frame_buffer #(.COLS(COLS)) u_frame_buffer (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr      (Wr),
        .wr_row  (Wr_row),
        .wr_data (Wr_data),
        .toggle  (Swap_ack),
        .rd_row  (row_n),
        .rd_data (rd_data)
    );

    assign row_adv = (row == ROW_LAST) ? ROW_FIRST : row + 3'd1;

    // row holds the decoder code directly; 0 only while idle.
    always_comb begin
        state_n = state;
        row_n   = row;
        cnt_n   = cnt;
        if (!En) begin
            state_n = ST_IDLE;
            row_n   = 3'd0;
            cnt_n   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    row_n = ROW_FIRST;
                    if (BLANK > 0) begin
                        state_n = ST_BLANK;
                        cnt_n   = BLANK_LD;
                    end else begin
                        state_n = ST_SHOW;
                        cnt_n   = DWELL_LD;
                    end
                end
                ST_BLANK: begin
                    if (cnt == '0) begin
                        state_n = ST_SHOW;
                        cnt_n   = DWELL_LD;
                    end else begin
                        cnt_n = cnt - 1'b1;
                    end
                end
                ST_SHOW: begin
                    if (cnt == '0) begin
                        row_n = row_adv;
                        if (BLANK > 0) begin
                            state_n = ST_BLANK;
                            cnt_n   = BLANK_LD;
                        end else begin
                            state_n = ST_SHOW;
                            cnt_n   = DWELL_LD;
                        end
                    end else begin
                        cnt_n = cnt - 1'b1;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    assign last_show_n = (state_n == ST_SHOW) && (row_n == ROW_LAST) && (cnt_n == '0);
    assign row_load    = (state_n == ST_SHOW) && ((state != ST_SHOW) || (cnt == '0));
    // Ack is raised for the frame's final lit cycle; the bank flips at the end of that cycle.
    assign swap_go     = !Swap_ack && (pending || Swap) &&
                         (last_show_n || (state == ST_IDLE && !En));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            row             <= 3'd0;
            cnt             <= '0;
            pending         <= 1'b0;
            Swap_ack        <= 1'b0;
            Frame_tick      <= 1'b0;
            V               <= 1'b0;
            {Ch2, Ch1, Ch0} <= 3'b000;
            Col             <= '0;
        end else begin
            state           <= state_n;
            row             <= row_n;
            cnt             <= cnt_n;
            pending         <= Swap_ack ? 1'b0 : (pending | Swap);
            Swap_ack        <= swap_go;
            Frame_tick      <= last_show_n;
            V               <= (state_n == ST_SHOW);
            {Ch2, Ch1, Ch0} <= row_n;
            if (state_n != ST_SHOW) Col <= '0;
            else if (row_load)      Col <= rd_data;
        end
    end

endmodule

// File: tb/tb_matrix_scan.sv
// tb/tb_matrix_scan.sv - scoreboard bench for matrix_scan with DWELL=4 and BLANK=2 or 0
module tb_matrix_scan;

    logic       clk = 1'b0;
    logic       rst_n, En, Wr, Swap;
    logic [2:0] Wr_row;
    logic [4:0] Wr_data;
    logic       Swap_ack, V, Ch2, Ch1, Ch0, Frame_tick;
    logic [4:0] Col;
    logic [2:0] ch;

    logic       en0, wr0, swap0;
    logic [2:0] wr_row0;
    logic [4:0] wr_data0;
    logic       swap_ack0, v0, ch2_0, ch1_0, ch0_0, tick0;
    logic [4:0] col0;
    logic [2:0] ch_0;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [2:0] ch;
        logic [4:0] col;
        int         len;
        bit         stable;
        bit         tick;
        bit         ack;
    } row_rec_t;

    row_rec_t   exp_q[$];
    row_rec_t   obs_q[$];
    logic [2:0] q0[$];
    row_rec_t   run;
    int         run_len = 0;

    always #5 clk = ~clk;

    assign ch   = {Ch2, Ch1, Ch0};
    assign ch_0 = {ch2_0, ch1_0, ch0_0};

    matrix_scan #(.DWELL(4), .BLANK(2), .COLS(5)) dut (
        .clk(clk), .rst_n(rst_n), .En(En), .Wr(Wr), .Wr_row(Wr_row), .Wr_data(Wr_data),
        .Swap(Swap), .Swap_ack(Swap_ack), .V(V), .Ch2(Ch2), .Ch1(Ch1), .Ch0(Ch0),
        .Col(Col), .Frame_tick(Frame_tick)
    );

    matrix_scan #(.DWELL(4), .BLANK(0), .COLS(5)) dut0 (
        .clk(clk), .rst_n(rst_n), .En(en0), .Wr(wr0), .Wr_row(wr_row0), .Wr_data(wr_data0),
        .Swap(swap0), .Swap_ack(swap_ack0), .V(v0), .Ch2(ch2_0), .Ch1(ch1_0), .Ch0(ch0_0),
        .Col(col0), .Frame_tick(tick0)
    );

    // Collapse each lit run of one row code into a record for the scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            run_len = 0;
        end else if (V) begin
            if (run_len != 0 && ch != run.ch) begin
                obs_q.push_back(run);
                run_len = 0;
            end
            if (run_len == 0) begin
                run.ch = ch; run.col = Col; run.stable = 1'b1; run.tick = 1'b0; run.ack = 1'b0;
            end else if (Col !== run.col) begin
                run.stable = 1'b0;
            end
            run_len++;
            run.len = run_len;
            if (Frame_tick) run.tick = 1'b1;
            if (Swap_ack)   run.ack  = 1'b1;
        end else if (run_len != 0) begin
            obs_q.push_back(run);
            run_len = 0;
        end
    end

    function automatic logic [18:0] pack(input row_rec_t r);
        return {r.ch, r.col, r.len[7:0], r.stable, r.tick, r.ack};
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; En = 1'b1; Wr = 1'b1; Wr_row = 3'd3; Wr_data = 5'h1F; Swap = 1'b1; en0 = 1'b1;
        repeat (3) begin
            step();
            n_checks++;
            if ({V, ch, Col, Swap_ack, Frame_tick, v0, swap_ack0, tick0} !== 14'h0) begin
                n_fail++;
                $display("FAIL reset_outputs: got V=%b Ch=%b Col=%b ack=%b tick=%b V0=%b, expected all 0",
                         V, ch, Col, Swap_ack, Frame_tick, v0);
            end
        end
        rst_n = 1'b1; En = 1'b0; Wr = 1'b0; Wr_row = 3'd0; Swap = 1'b0; en0 = 1'b0;
    endtask

    task automatic test_idle_swap();
        for (int r = 1; r <= 7; r++) begin
            Wr = 1'b1; Wr_row = 3'(r); Wr_data = 5'(r);
            step();
        end
        Wr_row = 3'd0; Wr_data = 5'h1F;
        step();
        Wr = 1'b0; Swap = 1'b1;
        step();
        Swap = 1'b0;
        n_checks++;
        if ({Swap_ack, V} !== 2'b10) begin
            n_fail++;
            $display("FAIL idle_swap_ack: got ack=%b V=%b, expected ack=1 V=0", Swap_ack, V);
        end
        step();
        n_checks++;
        if (Swap_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_swap_single: got ack=%b, expected 0", Swap_ack);
        end
    endtask

    task automatic test_first_frame();
        row_rec_t e, o;
        int tick_at = 0, ticks = 0;
        obs_q.delete();
        for (int r = 1; r <= 7; r++) begin
            e.ch = 3'(r); e.col = 5'(r); e.len = 4; e.stable = 1'b1; e.tick = (r == 7); e.ack = 1'b0;
            exp_q.push_back(e);
        end
        En = 1'b1;
        for (int c = 1; c <= 43; c++) begin
            step();
            if (c <= 2) begin
                n_checks++;
                if ({V, ch, Col} !== {1'b0, 3'b001, 5'h00}) begin
                    n_fail++;
                    $display("FAIL first_blank c=%0d: got V=%b Ch=%b Col=%b, expected V=0 Ch=001 Col=00000", c, V, ch, Col);
                end
            end
            if (Frame_tick) begin
                ticks++;
                if (tick_at == 0) tick_at = c;
            end
        end
        #1;
        n_checks++;
        if (tick_at != 42 || ticks != 1) begin
            n_fail++;
            $display("FAIL first_tick: got cycle=%0d count=%0d, expected cycle=42 count=1", tick_at, ticks);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL rows_frame1: row %0d missing, expected col=%h", e.ch, e.col);
            end else begin
                o = obs_q.pop_front();
                if (pack(o) !== pack(e)) begin
                    n_fail++;
                    $display("FAIL rows_frame1: got ch=%0d col=%h len=%0d st=%0b tk=%0b ack=%0b, expected ch=%0d col=%h len=%0d st=1 tk=%0b ack=%0b",
                             o.ch, o.col, o.len, o.stable, o.tick, o.ack, e.ch, e.col, e.len, e.tick, e.ack);
                end
            end
        end
    endtask

    task automatic test_mid_frame_swap();
        row_rec_t e, o;
        int acks = 0, stray = 0;
        obs_q.delete();
        for (int r = 1; r <= 7; r++) begin
            e.ch = 3'(r); e.col = 5'(r); e.len = 4; e.stable = 1'b1; e.tick = (r == 7); e.ack = (r == 7);
            exp_q.push_back(e);
        end
        for (int c = 44; c <= 85; c++) begin
            step();
            if (c == 58) begin Wr = 1'b1; Wr_row = 3'd3; Wr_data = 5'h1F; Swap = 1'b1; end
            if (c == 59) begin Wr = 1'b0; Swap = 1'b0; end
            if (c == 70) Swap = 1'b1;
            if (c == 71) Swap = 1'b0;
            if (Swap_ack) acks++;
            if (Swap_ack && !Frame_tick) stray++;
        end
        #1;
        n_checks++;
        if (acks != 1 || stray != 0) begin
            n_fail++;
            $display("FAIL merged_swap_ack: got acks=%0d off_tick=%0d, expected acks=1 off_tick=0", acks, stray);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL rows_frame2: row %0d missing, expected col=%h", e.ch, e.col);
            end else begin
                o = obs_q.pop_front();
                if (pack(o) !== pack(e)) begin
                    n_fail++;
                    $display("FAIL rows_frame2: got ch=%0d col=%h len=%0d st=%0b tk=%0b ack=%0b, expected ch=%0d col=%h len=%0d st=1 tk=%0b ack=%0b",
                             o.ch, o.col, o.len, o.stable, o.tick, o.ack, e.ch, e.col, e.len, e.tick, e.ack);
                end
            end
        end
    endtask

    task automatic test_next_frame();
        row_rec_t e, o;
        int acks = 0;
        obs_q.delete();
        for (int r = 1; r <= 7; r++) begin
            e.ch = 3'(r); e.col = (r == 3) ? 5'h1F : 5'h00; e.len = 4; e.stable = 1'b1;
            e.tick = (r == 7); e.ack = 1'b0;
            exp_q.push_back(e);
        end
        for (int c = 86; c <= 127; c++) begin
            step();
            if (Swap_ack) acks++;
        end
        #1;
        n_checks++;
        if (acks != 0) begin
            n_fail++;
            $display("FAIL no_second_ack: got acks=%0d, expected 0", acks);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL rows_frame3: row %0d missing, expected col=%h", e.ch, e.col);
            end else begin
                o = obs_q.pop_front();
                if (pack(o) !== pack(e)) begin
                    n_fail++;
                    $display("FAIL rows_frame3: got ch=%0d col=%h len=%0d st=%0b tk=%0b ack=%0b, expected ch=%0d col=%h len=%0d st=1 tk=%0b ack=%0b",
                             o.ch, o.col, o.len, o.stable, o.tick, o.ack, e.ch, e.col, e.len, e.tick, e.ack);
                end
            end
        end
    endtask

    task automatic test_en_drop();
        logic [8:0] want;
        int ticks = 0;
        for (int c = 128; c <= 165; c++) begin
            step();
            if (c == 154) En = 1'b0;
            if (c == 158) En = 1'b1;
            if (c >= 155 && Frame_tick) ticks++;
            if (c >= 155 && c <= 161) begin
                if (c <= 158)      want = {1'b0, 3'b000, 5'h00};
                else if (c <= 160) want = {1'b0, 3'b001, 5'h00};
                else               want = {1'b1, 3'b001, 5'h00};
                n_checks++;
                if ({V, ch, Col} !== want) begin
                    n_fail++;
                    $display("FAIL en_drop c=%0d: got V/Ch/Col=%b, expected %b", c, {V, ch, Col}, want);
                end
            end
        end
        n_checks++;
        if (ticks != 0) begin
            n_fail++;
            $display("FAIL en_drop_tick: got %0d ticks, expected 0", ticks);
        end
        obs_q.delete();
    endtask

    task automatic test_blank_zero();
        logic [2:0] e;
        for (int c = 1; c <= 32; c++) q0.push_back(3'(((c - 1) / 4) % 7 + 1));
        en0 = 1'b1;
        for (int c = 1; c <= 32; c++) begin
            step();
            e = q0.pop_front();
            n_checks++;
            if ({v0, ch_0, tick0} !== {1'b1, e, (c == 28)}) begin
                n_fail++;
                $display("FAIL blank0 c=%0d: got V=%b Ch=%b tick=%b, expected V=1 Ch=%b tick=%b",
                         c, v0, ch_0, tick0, e, (c == 28));
            end
        end
        en0 = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; En = 1'b0; Wr = 1'b0; Wr_row = 3'd0; Wr_data = 5'h00; Swap = 1'b0;
        en0 = 1'b0; wr0 = 1'b0; wr_row0 = 3'd0; wr_data0 = 5'h00; swap0 = 1'b0;
        test_reset();
        test_idle_swap();
        test_first_frame();
        test_mid_frame_swap();
        test_next_frame();
        test_en_drop();
        test_blank_zero();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
